// File: rtl/demux13_buf.sv
// demux13_buf: registered 1-to-13 distributor with single-entry holding slots.
// Each slot is drained by its own consumer through a valid/ack handshake.

// One holding slot: loads on accept, clears valid on drain, data holds.
module demux13_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);
  // Load wins over drain so a same-cycle reload keeps the slot full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

module demux13_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       s,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic [WIDTH-1:0] y8,
  output logic [WIDTH-1:0] y9,
  output logic [WIDTH-1:0] y10,
  output logic [WIDTH-1:0] y11,
  output logic [WIDTH-1:0] y12,
  output logic [12:0]      y_valid,
  input  logic [12:0]      y_ack,
  output logic [3:0]       occ,
  output logic             sel_err
);
  localparam int N = 13;

  logic [N-1:0][WIDTH-1:0] y_q;
  logic [N-1:0]            drain, load, free;
  logic [15:0]             free_ext;
  logic                    legal, accept, inc;
  logic [3:0]              dec, occ_next;

  assign legal    = (s <= 4'd12);
  assign drain    = y_valid & y_ack;
  assign free     = ~y_valid | y_ack;
  // Illegal selects always accept (word is discarded), so pad with ones.
  assign free_ext = {3'b111, free};
  assign in_ready = free_ext[s];
  assign accept   = in_valid & in_ready;

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_slot
      assign load[k] = accept & legal & (s == 4'(k));
      demux13_slot #(.WIDTH(WIDTH)) u_slot (
        .clk   (clk),
        .reset (reset),
        .load  (load[k]),
        .drain (drain[k]),
        .d     (d),
        .q     (y_q[k]),
        .valid (y_valid[k])
      );
    end
  endgenerate

  // Occupancy delta: +1 for a load into an empty-or-staying slot, -1 per drain not refilled.
  always_comb begin
    inc = |(load & ~drain);
    dec = '0;
    for (int i = 0; i < N; i++) dec = dec + {3'b000, drain[i] & ~load[i]};
    occ_next = occ + {3'b000, inc} - dec;
  end

  // Registered occupancy count and illegal-select pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ     <= '0;
      sel_err <= 1'b0;
    end else begin
      occ     <= occ_next;
      sel_err <= accept & ~legal;
    end
  end

  assign y0  = y_q[0];
  assign y1  = y_q[1];
  assign y2  = y_q[2];
  assign y3  = y_q[3];
  assign y4  = y_q[4];
  assign y5  = y_q[5];
  assign y6  = y_q[6];
  assign y7  = y_q[7];
  assign y8  = y_q[8];
  assign y9  = y_q[9];
  assign y10 = y_q[10];
  assign y11 = y_q[11];
  assign y12 = y_q[12];
endmodule

// File: tb/tb_demux13_buf.sv
// Testbench for demux13_buf: scenario tasks plus a slot scoreboard.
module tb_demux13_buf;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  s;
  logic [7:0]  d;
  logic [7:0]  y0, y1, y2, y3, y4, y5, y6, y7, y8, y9, y10, y11, y12;
  logic [12:0] y_valid;
  logic [12:0] y_ack;
  logic [3:0]  occ;
  logic        sel_err;

  logic [7:0]  yv [13];
  assign yv[0] = y0;   assign yv[1] = y1;   assign yv[2] = y2;
  assign yv[3] = y3;   assign yv[4] = y4;   assign yv[5] = y5;
  assign yv[6] = y6;   assign yv[7] = y7;   assign yv[8] = y8;
  assign yv[9] = y9;   assign yv[10] = y10; assign yv[11] = y11;
  assign yv[12] = y12;

  demux13_buf #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .d(d),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6),
    .y7(y7), .y8(y8), .y9(y9), .y10(y10), .y11(y11), .y12(y12),
    .y_valid(y_valid), .y_ack(y_ack), .occ(occ), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic [7:0] data;
  } exp_t;

  exp_t        q[$];
  logic [12:0] m_valid;
  logic        m_err;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // One clock: check ready, update model, push expected, then compare after the edge.
  task automatic cycle();
    logic exp_rdy, acc;
    exp_t e;
    #1;
    exp_rdy = (s > 4'd12) ? 1'b1 : (~m_valid[s] | y_ack[s]);
    total_cnt++;
    if (in_ready !== exp_rdy) $display("FAIL in_ready s=%0d got %b exp %b", s, in_ready, exp_rdy);
    else pass_cnt++;
    acc = in_valid & exp_rdy;
    m_valid = m_valid & ~y_ack;
    if (acc && s <= 4'd12) begin
      m_valid[s] = 1'b1;
      e.slot = int'(s);
      e.data = d;
      q.push_back(e);
    end
    m_err = acc && (s > 4'd12);
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      total_cnt++;
      if (yv[e.slot] !== e.data || y_valid[e.slot] !== 1'b1)
        $display("FAIL slot_data y%0d got %h/%b exp %h/1", e.slot, yv[e.slot], y_valid[e.slot], e.data);
      else pass_cnt++;
    end
    total_cnt++;
    if (y_valid !== m_valid) $display("FAIL y_valid got %h exp %h", y_valid, m_valid);
    else pass_cnt++;
    total_cnt++;
    if (occ !== 4'($countones(m_valid))) $display("FAIL occ got %0d exp %0d", occ, $countones(m_valid));
    else pass_cnt++;
    total_cnt++;
    if (sel_err !== m_err) $display("FAIL sel_err got %b exp %b", sel_err, m_err);
    else pass_cnt++;
  endtask

  task automatic idle();
    in_valid = 1'b0; y_ack = '0; s = '0; d = '0;
  endtask

  task automatic test_reset();
    // Power-on reset state
    total_cnt++;
    if (y_valid !== 13'h0 || occ !== 4'd0 || sel_err !== 1'b0 || y5 !== 8'h00)
      $display("FAIL por_state got v=%h occ=%0d err=%b y5=%h exp 0", y_valid, occ, sel_err, y5);
    else pass_cnt++;
    reset = 1'b0;
    // Fill slots 0, 5, 12 then reset mid-cycle
    in_valid = 1'b1;
    s = 4'd0;  d = 8'h10; cycle();
    s = 4'd5;  d = 8'h55; cycle();
    s = 4'd12; d = 8'hC2; cycle();
    idle();
    #2 reset = 1'b1;
    s = 4'd5;
    #1;
    total_cnt++;
    if (y_valid !== 13'h0 || occ !== 4'd0) $display("FAIL reset_mid got v=%h occ=%0d exp 0/0", y_valid, occ);
    else pass_cnt++;
    for (int k = 0; k < 13; k++) begin
      total_cnt++;
      if (yv[k] !== 8'h00) $display("FAIL reset_y%0d got %h exp 00", k, yv[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready);
    else pass_cnt++;
    m_valid = '0; m_err = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_single_write();
    idle();
    in_valid = 1'b1; s = 4'd3; d = 8'hA5; cycle();
    total_cnt++;
    if (y3 !== 8'hA5 || y_valid !== 13'h0008 || occ !== 4'd1)
      $display("FAIL single_write got y3=%h v=%h occ=%0d exp A5/0008/1", y3, y_valid, occ);
    else pass_cnt++;
    d = 8'h5A; #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL full_block got %b exp 0", in_ready);
    else pass_cnt++;
    cycle();
    y_ack = 13'h0008; cycle();
    total_cnt++;
    if (y3 !== 8'h5A || occ !== 4'd1) $display("FAIL reload got y3=%h occ=%0d exp 5A/1", y3, occ);
    else pass_cnt++;
    in_valid = 1'b0; cycle();
    total_cnt++;
    if (y3 !== 8'h5A || y_valid[3] !== 1'b0) $display("FAIL drain_hold got y3=%h v=%b exp 5A/0", y3, y_valid[3]);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    idle();
    in_valid = 1'b1; s = 4'd7; y_ack = 13'h0080;
    for (int i = 0; i < 3; i++) begin
      d = words[i];
      cycle();
      total_cnt++;
      if (y7 !== words[i] || y_valid[7] !== 1'b1 || occ !== 4'd1)
        $display("FAIL b2b_%0d got y7=%h v=%b occ=%0d exp %h/1/1", i, y7, y_valid[7], occ, words[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0; cycle();
    idle();
  endtask

  task automatic test_fill_all();
    idle();
    in_valid = 1'b1;
    for (int k = 0; k < 13; k++) begin
      s = 4'(k); d = 8'(8'h40 + k); cycle();
    end
    total_cnt++;
    if (occ !== 4'd13 || y_valid !== 13'h1FFF) $display("FAIL fill_all got occ=%0d v=%h exp 13/1FFF", occ, y_valid);
    else pass_cnt++;
    for (int k = 0; k < 13; k++) begin
      s = 4'(k); #1;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL full_ready s=%0d got %b exp 0", k, in_ready);
      else pass_cnt++;
    end
    in_valid = 1'b0; y_ack = 13'h1FFF; cycle();
    total_cnt++;
    if (occ !== 4'd0) $display("FAIL ack_all got occ=%0d exp 0", occ);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_illegal_sel();
    logic [3:0] bad [2];
    bad[0] = 4'hD; bad[1] = 4'hF;
    idle();
    in_valid = 1'b1; s = 4'd2; d = 8'h22; cycle();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; s = bad[i]; d = 8'hEE; #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL illegal_ready s=%h got %b exp 1", bad[i], in_ready);
      else pass_cnt++;
      cycle();
      total_cnt++;
      if (sel_err !== 1'b1 || y_valid !== 13'h0004 || occ !== 4'd1)
        $display("FAIL illegal_sel s=%h got err=%b v=%h occ=%0d exp 1/0004/1", bad[i], sel_err, y_valid, occ);
      else pass_cnt++;
      in_valid = 1'b0; cycle();
      total_cnt++;
      if (sel_err !== 1'b0) $display("FAIL sel_err_pulse got %b exp 0", sel_err);
      else pass_cnt++;
    end
    y_ack = 13'h0004; cycle();
    idle();
  endtask

  task automatic test_spurious_ack();
    idle();
    y_ack = 13'h1FFF; cycle();
    total_cnt++;
    if (y_valid !== 13'h0 || occ !== 4'd0) $display("FAIL spurious_ack got v=%h occ=%0d exp 0/0", y_valid, occ);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      s        = 4'($urandom_range(0, 15));
      d        = 8'($urandom);
      y_ack    = 13'($urandom) & 13'($urandom);
      cycle();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    m_valid = '0; m_err = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_fill_all();
    test_illegal_sel();
    test_spurious_ack();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
